// File: rtl/label_table_pkg.sv
// Shared definitions for the label table: opcodes, controller state codes, fault codes.
package label_table_pkg;

    localparam int unsigned LT_LBL_W  = 8;
    localparam int unsigned LT_ADDR_W = 16;
    localparam int unsigned OPT_W     = 8;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned FAULT_W   = 2;

    localparam logic [7:0] OP_LBSET  = 8'h1E;
    localparam logic [7:0] OP_PLIMM  = 8'h03;
    localparam logic [7:0] P3F_REGNO = 8'h3F;

    localparam logic [STATE_W-1:0] STATE_EXEC = 4'd4;

    localparam logic [FAULT_W-1:0] FAULT_NONE  = 2'd0;
    localparam logic [FAULT_W-1:0] FAULT_UNDEF = 2'd1;
    localparam logic [FAULT_W-1:0] FAULT_RANGE = 2'd2;
    localparam logic [FAULT_W-1:0] FAULT_BUSY  = 2'd3;

    // Decoded view of instruction word 0.
    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  fa;
        logic [15:0] fb;
    } instr_t;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } lt_state_e;

endpackage

// File: rtl/label_table_if.sv
// Controller-facing bus of the label table: instruction/pc in, jump request and status out.
interface label_table_if #(
    parameter int unsigned LBL_W  = 8,
    parameter int unsigned ADDR_W = 16
);
    logic [3:0]        current_state;
    logic [31:0]       instr0;
    logic [31:0]       instr1;
    logic [ADDR_W-1:0] pc;
    logic              pc_update_req;
    logic [ADDR_W-1:0] pc_update_addr;
    logic              busy;
    logic              fault;
    logic [1:0]        fault_code;
    logic [LBL_W:0]    lbl_count;

    modport master (
        output current_state, instr0, instr1, pc,
        input  pc_update_req, pc_update_addr, busy, fault, fault_code, lbl_count
    );

    modport slave (
        input  current_state, instr0, instr1, pc,
        output pc_update_req, pc_update_addr, busy, fault, fault_code, lbl_count
    );
endinterface

// File: rtl/label_table_ram.sv
// Label storage: async-read / sync-write entry array plus a valid-bit vector with per-entry clear.
module label_ram #(
    parameter int unsigned LBL_W  = 8,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LBL_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LBL_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wvalid,
    input  logic              vclr,
    input  logic [LBL_W-1:0]  vclr_idx
);
    localparam int unsigned DEPTH = 1 << LBL_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Entry write at the end of the LBSET EXEC cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Valid bits: sweep clear has priority; clear and set never coincide in practice.
    always_ff @(posedge clk) begin
        if (vclr) begin
            valid[vclr_idx] <= 1'b0;
        end else if (we) begin
            valid[waddr] <= 1'b1;
        end
    end

    assign rdata  = mem[raddr];
    assign rvalid = valid[raddr];
    assign wvalid = valid[waddr];

endmodule

// File: rtl/label_table.sv
// Label table: records LBSET label definitions and resolves PLIMM P3F jumps for the controller.
module label_table
    import label_table_pkg::*;
#(
    parameter int unsigned LBL_W  = LT_LBL_W,
    parameter int unsigned ADDR_W = LT_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    label_table_if.slave  bus
);
    localparam int unsigned DEPTH  = 1 << LBL_W;
    localparam int unsigned DATA_W = ADDR_W + OPT_W;

    lt_state_e          state;
    logic [LBL_W-1:0]   idx;
    logic               busy;
    logic               fault;
    logic [FAULT_W-1:0] fault_code;
    logic [LBL_W:0]     lbl_count;

    instr_t             i0;
    logic               exec_c;
    logic               ready_c;
    logic               lbset_c;
    logic               jump_c;
    logic               set_in_range_c;
    logic               jump_in_range_c;
    logic               we_c;
    logic               hit_c;
    logic [LBL_W-1:0]   set_lbl_c;
    logic [LBL_W-1:0]   jump_lbl_c;
    logic [DATA_W-1:0]  rdata;
    logic               rvalid;
    logic               wvalid;
    logic               flt_c;
    logic [FAULT_W-1:0] flt_code_c;
    logic               unused_opt;

    assign i0              = bus.instr0;
    assign exec_c          = (bus.current_state == STATE_EXEC);
    assign ready_c         = (state == ST_READY);
    assign lbset_c         = exec_c && (i0.op == OP_LBSET);
    assign jump_c          = exec_c && (i0.op == OP_PLIMM) && (i0.fa == P3F_REGNO);
    assign set_lbl_c       = bus.instr1[LBL_W-1:0];
    assign jump_lbl_c      = i0.fb[LBL_W-1:0];
    assign set_in_range_c  = ((bus.instr1 >> LBL_W) == '0);
    assign jump_in_range_c = ((i0.fb >> LBL_W) == '0);
    assign we_c            = lbset_c && ready_c && set_in_range_c;
    assign hit_c           = jump_c && ready_c && jump_in_range_c && rvalid;

    label_ram #(
        .LBL_W  (LBL_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk      (clk),
        .we       (we_c),
        .waddr    (set_lbl_c),
        .wdata    ({i0.fa, bus.pc}),
        .raddr    (jump_lbl_c),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .wvalid   (wvalid),
        .vclr     (state == ST_CLEAR),
        .vclr_idx (idx)
    );

    // The stored option byte is kept for downstream consumers; the jump path only needs the address.
    assign unused_opt = ^rdata[DATA_W-1:ADDR_W];

    // Zero-latency jump request toward the controller.
    assign bus.pc_update_req  = hit_c;
    assign bus.pc_update_addr = hit_c ? rdata[ADDR_W-1:0] : '0;

    // Fault classification for the current EXEC instruction.
    always_comb begin
        flt_c      = 1'b0;
        flt_code_c = FAULT_NONE;
        if (lbset_c && ready_c && !set_in_range_c) begin
            flt_c      = 1'b1;
            flt_code_c = FAULT_RANGE;
        end else if (jump_c) begin
            if (!ready_c) begin
                flt_c      = 1'b1;
                flt_code_c = FAULT_BUSY;
            end else if (!jump_in_range_c) begin
                flt_c      = 1'b1;
                flt_code_c = FAULT_RANGE;
            end else if (!rvalid) begin
                flt_c      = 1'b1;
                flt_code_c = FAULT_UNDEF;
            end
        end
    end

    // Clear-sweep FSM, label count and sticky first-fault capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            idx        <= '0;
            busy       <= 1'b1;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            lbl_count  <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    idx <= idx + LBL_W'(1);
                    if (idx == LBL_W'(DEPTH - 1)) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (we_c && !wvalid) begin
                        lbl_count <= lbl_count + (LBL_W + 1)'(1);
                    end
                end
                default: state <= ST_CLEAR;
            endcase
            if (flt_c && !fault) begin
                fault      <= 1'b1;
                fault_code <= flt_code_c;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.fault      = fault;
    assign bus.fault_code = fault_code;
    assign bus.lbl_count  = lbl_count;

endmodule

// File: doc/label_table.md
Name: label_table

Overview:
- Branch-target stage downstream of the fetch/exec controller.
- Consumes the decoded instruction words (instr0/instr1), the controller state and the pc.
- Records label definitions (LBSET) and resolves label-based jumps (PLIMM to P3F).
- Drives the controller's pc_update_req / pc_update_addr during the EXEC state.
- Holds a DEPTH-entry label RAM with valid bits, cleared by a hardware sweep after reset.

Parameters:
- LBL_W, 8: label-number width; DEPTH = 2**LBL_W entries.
- ADDR_W, 16: program-address width; matches pc width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- current_state  in  4  controller state code; only STATE_EXEC is acted on.
- instr0  in  32  first instruction word: [31:24] op, [23:16] field A, [15:0] field B.
- instr1  in  32  second instruction word (LBSET only).
- pc  in  ADDR_W  controller pc; during EXEC it already points at the next instruction.
- pc_update_req  out  1  jump request, valid during EXEC only.
- pc_update_addr  out  ADDR_W  jump target.
- busy  out  1  high while the clear sweep runs; the top level ORs this into the controller reset.
- fault  out  1  sticky error flag.
- fault_code  out  2  0 none, 1 undefined label, 2 label out of range, 3 jump while busy.
- lbl_count  out  LBL_W+1  number of valid entries.

Behaviour:
- FSM states: CLEAR and READY.
  - Any posedge with reset=1 forces CLEAR, idx<=0, busy=1, fault=0, fault_code=0, lbl_count=0. This applies even mid-sweep; the sweep restarts at 0.
  - In CLEAR, each posedge clears valid[idx] and increments idx. After the cycle that clears entry DEPTH-1, the FSM goes to READY.
  - busy is high for exactly DEPTH cycles after the reset edge. The FSM never returns to CLEAR without reset.
- pc_update_req and pc_update_addr are combinational.
  - Outside STATE_EXEC, or in CLEAR: req=0, addr=0.
- LBSET (op==OP_LBSET, READY, STATE_EXEC):
  - Label L = instr1[LBL_W-1:0].
  - If instr1[31:LBL_W] != 0: no write; fault<=1, code 2.
  - Otherwise, at the posedge ending EXEC: addr[L]<=pc, opt[L]<=instr0[23:16], valid[L]<=1.
  - lbl_count increments only if L was previously invalid. Redefinition overwrites with no fault.
  - pc_update_req stays 0.
- PLIMM (op==OP_PLIMM, STATE_EXEC), label L = instr0[15:0]:
  - Field A==8'h3F (P3F) and READY:
    - L in range and valid[L]: req=1, addr=addr[L] in the same cycle (zero-latency read).
    - L invalid: req=0; fault<=1, code 1.
    - L >= DEPTH: req=0; fault<=1, code 2.
  - Field A==8'h3F in CLEAR: req=0; fault<=1, code 3.
  - Field A != 8'h3F: no action (the pointer-register file handles it).
- Other ops: no action.
- Fault recording: first fault wins. fault_code holds until reset; later faults do not overwrite it.
- No hazards: the controller executes one instruction per EXEC, so a write and a lookup never coincide. An LBSET immediately followed by a PLIMM to the same label sees the new entry, because the write lands at the end of the LBSET EXEC cycle.
- Skipped instructions never reach EXEC and are ignored.

Decomposition:
- Shared definitions file (existing) supplies: OP_LBSET, OP_PLIMM, STATE_EXEC, and the new constants P3F_REGNO=8'h3F and FAULT_* codes.
- Sub-module label_ram: DEPTH x (ADDR_W+8) storage with async read and sync write, plus a separate valid-bit vector with per-entry clear. label_table instantiates it and holds the FSM, sweep counter, fault logic and lbl_count.

Test Plan:
- Reset sequence: assert reset 1 cycle, release -> busy=1 for exactly 256 cycles, then 0; lbl_count=0, fault=0.
- LBSET label 5 at pc=0x0012, then PLIMM P3F label 5 -> during that EXEC req=1, addr=0x0012; lbl_count=1.
- Redefinition: LBSET 5 at pc=0x0020 -> lbl_count stays 1; next jump addr=0x0020; no fault.
- PLIMM P3F label 7 (never set) -> req=0, fault=1, code=1; a later out-of-range PLIMM label 0x0100 leaves code=1 (first fault wins).
- Reset asserted at sweep cycle 100 -> sweep restarts; busy stays high 256 cycles from the new reset edge; a PLIMM P3F during the sweep gives code 3.
- PLIMM with field A=0x01 and non-EXEC states carrying OP_PLIMM/P3F -> req=0 and no table or fault change.
